// File: rtl/idct_block_loader.sv
// idct_block_loader: feeder for the 64-input IDCT pipeline.
// Accepts one signed coefficient per cycle over a valid/ready stream and
// scatters it into an 8x8 fill bank. Each completed block is copied into
// the presentation bank, which drives x0..x63 (raster order, x[8*row+col]).
// The fill bank is zeroed in the same cycle, so a short block reads 0 in its
// unwritten slots. A second block may complete while the first is still
// presented; the loader then stalls (in_ready=0) until out_ready takes it.
//
// Build option: define IDCT_LOADER_ZIGZAG_EN to de-zigzag input in JPEG
// zigzag order. Without it the input is taken as already in raster order.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_data/in_valid      signed coefficient stream
//   in_last               end-of-block marker (qualified by in_valid)
//   in_ready              loader can accept a coefficient
//   out_valid/out_ready   presented-block handshake
//   x0..x63               presented block
//   err_len               one-cycle pulse on a block-length violation
module idct_block_loader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BLK_N  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] x0,
  output logic signed [DATA_W-1:0] x1,
  output logic signed [DATA_W-1:0] x2,
  output logic signed [DATA_W-1:0] x3,
  output logic signed [DATA_W-1:0] x4,
  output logic signed [DATA_W-1:0] x5,
  output logic signed [DATA_W-1:0] x6,
  output logic signed [DATA_W-1:0] x7,
  output logic signed [DATA_W-1:0] x8,
  output logic signed [DATA_W-1:0] x9,
  output logic signed [DATA_W-1:0] x10,
  output logic signed [DATA_W-1:0] x11,
  output logic signed [DATA_W-1:0] x12,
  output logic signed [DATA_W-1:0] x13,
  output logic signed [DATA_W-1:0] x14,
  output logic signed [DATA_W-1:0] x15,
  output logic signed [DATA_W-1:0] x16,
  output logic signed [DATA_W-1:0] x17,
  output logic signed [DATA_W-1:0] x18,
  output logic signed [DATA_W-1:0] x19,
  output logic signed [DATA_W-1:0] x20,
  output logic signed [DATA_W-1:0] x21,
  output logic signed [DATA_W-1:0] x22,
  output logic signed [DATA_W-1:0] x23,
  output logic signed [DATA_W-1:0] x24,
  output logic signed [DATA_W-1:0] x25,
  output logic signed [DATA_W-1:0] x26,
  output logic signed [DATA_W-1:0] x27,
  output logic signed [DATA_W-1:0] x28,
  output logic signed [DATA_W-1:0] x29,
  output logic signed [DATA_W-1:0] x30,
  output logic signed [DATA_W-1:0] x31,
  output logic signed [DATA_W-1:0] x32,
  output logic signed [DATA_W-1:0] x33,
  output logic signed [DATA_W-1:0] x34,
  output logic signed [DATA_W-1:0] x35,
  output logic signed [DATA_W-1:0] x36,
  output logic signed [DATA_W-1:0] x37,
  output logic signed [DATA_W-1:0] x38,
  output logic signed [DATA_W-1:0] x39,
  output logic signed [DATA_W-1:0] x40,
  output logic signed [DATA_W-1:0] x41,
  output logic signed [DATA_W-1:0] x42,
  output logic signed [DATA_W-1:0] x43,
  output logic signed [DATA_W-1:0] x44,
  output logic signed [DATA_W-1:0] x45,
  output logic signed [DATA_W-1:0] x46,
  output logic signed [DATA_W-1:0] x47,
  output logic signed [DATA_W-1:0] x48,
  output logic signed [DATA_W-1:0] x49,
  output logic signed [DATA_W-1:0] x50,
  output logic signed [DATA_W-1:0] x51,
  output logic signed [DATA_W-1:0] x52,
  output logic signed [DATA_W-1:0] x53,
  output logic signed [DATA_W-1:0] x54,
  output logic signed [DATA_W-1:0] x55,
  output logic signed [DATA_W-1:0] x56,
  output logic signed [DATA_W-1:0] x57,
  output logic signed [DATA_W-1:0] x58,
  output logic signed [DATA_W-1:0] x59,
  output logic signed [DATA_W-1:0] x60,
  output logic signed [DATA_W-1:0] x61,
  output logic signed [DATA_W-1:0] x62,
  output logic signed [DATA_W-1:0] x63,
  output logic                     err_len
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLK_N - 1);

  typedef enum logic [0:0] {S_FILL, S_FULL} state_t;

  // Zigzag position -> raster index.
`ifdef IDCT_LOADER_ZIGZAG_EN
  localparam logic [CNT_W-1:0] ZZ_TAB [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [CNT_W-1:0] raster_idx(input logic [CNT_W-1:0] pos);
    return ZZ_TAB[pos];
  endfunction
`else
  function automatic logic [CNT_W-1:0] raster_idx(input logic [CNT_W-1:0] pos);
    return pos;
  endfunction
`endif

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic signed [DATA_W-1:0] fill_q  [BLK_N];
  logic signed [DATA_W-1:0] pres_q  [BLK_N];
  logic signed [DATA_W-1:0] fill_wr [BLK_N];

  logic             xfer_in;
  logic             xfer_out;
  logic             done;
  logic             pres_free;
  logic [CNT_W-1:0] wr_idx;

  // Handshakes, completion detect, and the fill bank with this cycle's write merged.
  always_comb begin
    xfer_in   = in_valid && in_ready;
    xfer_out  = out_valid && out_ready;
    done      = xfer_in && (in_last || (cnt == CNT_MAX));
    pres_free = !out_valid || out_ready;
    wr_idx    = raster_idx(cnt);
    for (int unsigned i = 0; i < BLK_N; i++) begin
      fill_wr[6'(i)] = fill_q[6'(i)];
    end
    if (xfer_in) begin
      fill_wr[wr_idx] = in_data;
    end
  end

  // Loader FSM and both banks; a swap copies fill into pres and zeroes fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FILL;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      err_len   <= 1'b0;
      for (int unsigned i = 0; i < BLK_N; i++) begin
        fill_q[6'(i)] <= '0;
        pres_q[6'(i)] <= '0;
      end
    end else begin
      err_len <= 1'b0;
      case (state)
        S_FILL: begin
          if (xfer_in) begin
            cnt <= cnt + CNT_W'(1);
            for (int unsigned i = 0; i < BLK_N; i++) begin
              fill_q[6'(i)] <= fill_wr[6'(i)];
            end
          end
          if (done) begin
            // Error unless in_last coincides exactly with the 64th word.
            err_len <= in_last ^ (cnt == CNT_MAX);
            if (pres_free) begin
              cnt       <= '0;
              out_valid <= 1'b1;
              for (int unsigned i = 0; i < BLK_N; i++) begin
                pres_q[6'(i)] <= fill_wr[6'(i)];
                fill_q[6'(i)] <= '0;
              end
            end else begin
              // Hold the completed block in the fill bank until pres drains.
              cnt      <= cnt;
              state    <= S_FULL;
              in_ready <= 1'b0;
            end
          end else if (xfer_out) begin
            out_valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (xfer_out) begin
            state     <= S_FILL;
            in_ready  <= 1'b1;
            cnt       <= '0;
            out_valid <= 1'b1;
            for (int unsigned i = 0; i < BLK_N; i++) begin
              pres_q[6'(i)] <= fill_q[6'(i)];
              fill_q[6'(i)] <= '0;
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  assign x0  = pres_q[0];
  assign x1  = pres_q[1];
  assign x2  = pres_q[2];
  assign x3  = pres_q[3];
  assign x4  = pres_q[4];
  assign x5  = pres_q[5];
  assign x6  = pres_q[6];
  assign x7  = pres_q[7];
  assign x8  = pres_q[8];
  assign x9  = pres_q[9];
  assign x10 = pres_q[10];
  assign x11 = pres_q[11];
  assign x12 = pres_q[12];
  assign x13 = pres_q[13];
  assign x14 = pres_q[14];
  assign x15 = pres_q[15];
  assign x16 = pres_q[16];
  assign x17 = pres_q[17];
  assign x18 = pres_q[18];
  assign x19 = pres_q[19];
  assign x20 = pres_q[20];
  assign x21 = pres_q[21];
  assign x22 = pres_q[22];
  assign x23 = pres_q[23];
  assign x24 = pres_q[24];
  assign x25 = pres_q[25];
  assign x26 = pres_q[26];
  assign x27 = pres_q[27];
  assign x28 = pres_q[28];
  assign x29 = pres_q[29];
  assign x30 = pres_q[30];
  assign x31 = pres_q[31];
  assign x32 = pres_q[32];
  assign x33 = pres_q[33];
  assign x34 = pres_q[34];
  assign x35 = pres_q[35];
  assign x36 = pres_q[36];
  assign x37 = pres_q[37];
  assign x38 = pres_q[38];
  assign x39 = pres_q[39];
  assign x40 = pres_q[40];
  assign x41 = pres_q[41];
  assign x42 = pres_q[42];
  assign x43 = pres_q[43];
  assign x44 = pres_q[44];
  assign x45 = pres_q[45];
  assign x46 = pres_q[46];
  assign x47 = pres_q[47];
  assign x48 = pres_q[48];
  assign x49 = pres_q[49];
  assign x50 = pres_q[50];
  assign x51 = pres_q[51];
  assign x52 = pres_q[52];
  assign x53 = pres_q[53];
  assign x54 = pres_q[54];
  assign x55 = pres_q[55];
  assign x56 = pres_q[56];
  assign x57 = pres_q[57];
  assign x58 = pres_q[58];
  assign x59 = pres_q[59];
  assign x60 = pres_q[60];
  assign x61 = pres_q[61];
  assign x62 = pres_q[62];
  assign x63 = pres_q[63];

endmodule

// File: tb/tb_idct_block_loader.sv
// Bench for idct_block_loader: directed vector table, hand-built corner
// sequences and a randomized stream, all checked against a block-queue model.
module tb_idct_block_loader;

  typedef logic signed [15:0] blk_t [64];

  typedef struct {
    logic               v;
    logic signed [15:0] d;
    logic               l;
    logic               o;
    logic               eov;
    logic               eir;
    logic               eerr;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] in_data;
  logic               in_valid, in_last, out_ready;
  logic               in_ready, out_valid, err_len;
  logic signed [15:0] x [64];

  int checks = 0;
  int errors = 0;

  // Reference model: completed blocks wait in a two-deep queue (presented + held).
  int    zz [64];
  blk_t  m_fill;
  int    m_cnt;
  blk_t  m_pend [2];
  int    m_n;
  blk_t  m_x;
  logic  m_err;

  always #5 clk = ~clk;

  idct_block_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .err_len(err_len),
    .x0(x[0]),   .x1(x[1]),   .x2(x[2]),   .x3(x[3]),   .x4(x[4]),   .x5(x[5]),   .x6(x[6]),   .x7(x[7]),
    .x8(x[8]),   .x9(x[9]),   .x10(x[10]), .x11(x[11]), .x12(x[12]), .x13(x[13]), .x14(x[14]), .x15(x[15]),
    .x16(x[16]), .x17(x[17]), .x18(x[18]), .x19(x[19]), .x20(x[20]), .x21(x[21]), .x22(x[22]), .x23(x[23]),
    .x24(x[24]), .x25(x[25]), .x26(x[26]), .x27(x[27]), .x28(x[28]), .x29(x[29]), .x30(x[30]), .x31(x[31]),
    .x32(x[32]), .x33(x[33]), .x34(x[34]), .x35(x[35]), .x36(x[36]), .x37(x[37]), .x38(x[38]), .x39(x[39]),
    .x40(x[40]), .x41(x[41]), .x42(x[42]), .x43(x[43]), .x44(x[44]), .x45(x[45]), .x46(x[46]), .x47(x[47]),
    .x48(x[48]), .x49(x[49]), .x50(x[50]), .x51(x[51]), .x52(x[52]), .x53(x[53]), .x54(x[54]), .x55(x[55]),
    .x56(x[56]), .x57(x[57]), .x58(x[58]), .x59(x[59]), .x60(x[60]), .x61(x[61]), .x62(x[62]), .x63(x[63])
  );

  // Zigzag order derived by walking the anti-diagonals of the 8x8 grid.
  function automatic void build_zz();
    int k = 0;
`ifdef IDCT_LOADER_ZIGZAG_EN
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[k] = 8 * r + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[k] = 8 * r + (s - r); k++; end
      end
    end
`else
    for (int i = 0; i < 64; i++) begin zz[i] = i; k++; end
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_fill[i] = '0; m_x[i] = '0; m_pend[0][i] = '0; m_pend[1][i] = '0;
    end
    m_cnt = 0; m_n = 0; m_err = 1'b0;
  endfunction

  // One clock edge of the model, using the handshake state from before the edge.
  function automatic void model_step(input logic v, input logic signed [15:0] d,
                                     input logic l, input logic o);
    logic in_x, out_x, complete;
    in_x     = v && (m_n < 2);
    out_x    = o && (m_n > 0);
    complete = 1'b0;
    m_err    = 1'b0;
    if (out_x) begin
      m_pend[0] = m_pend[1];
      m_n--;
    end
    if (in_x) begin
      m_fill[zz[m_cnt]] = d;
      if (l || m_cnt == 63) begin
        complete = 1'b1;
        m_err = l ^ (m_cnt == 63);
        m_pend[m_n] = m_fill;
        m_n++;
        for (int i = 0; i < 64; i++) m_fill[i] = '0;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    if (m_n > 0 && (out_x || (complete && m_n == 1))) m_x = m_pend[0];
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int bad = -1;
    chk({tag, ".in_ready"},  64'(in_ready),  64'(m_n < 2));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_n > 0));
    chk({tag, ".err_len"},   64'(err_len),   64'(m_err));
    for (int i = 63; i >= 0; i--) if (x[i] !== m_x[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s.x[%0d]: got %0d expected %0d", tag, bad, x[bad], m_x[bad]);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic signed [15:0] d,
                      input logic l, input logic o);
    in_valid = v; in_data = d; in_last = l; out_ready = o;
    @(posedge clk);
    model_step(v, d, l, o);
    #1;
    check_all(tag);
  endtask

  vec_t        tv [6];
  logic signed [15:0] blk_a [64];
  logic signed [15:0] rv;

  initial begin
    build_zz();
    model_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #12;
    check_all("reset");
    @(negedge clk) rst = 1'b0;

    // Short block 13,-7,0,0,2 with early in_last.
    tv[0] = '{1'b1, 16'sd13, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[1] = '{1'b1, -16'sd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[2] = '{1'b1, 16'sd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[3] = '{1'b1, 16'sd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[4] = '{1'b1, 16'sd2,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tv[5] = '{1'b0, 16'sd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step("short", tv[i].v, tv[i].d, tv[i].l, tv[i].o);
      chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(tv[i].eov));
      chk($sformatf("vec%0d.in_ready", i),  64'(in_ready),  64'(tv[i].eir));
      chk($sformatf("vec%0d.err_len", i),   64'(err_len),   64'(tv[i].eerr));
    end
    chk("short.x0", x[0], 13);
    chk("short.x1", x[1], -7);
    chk("short.x_pos4", x[zz[4]], 2);
    chk("short.x63", x[63], 0);

    // Full block 0..63, in_last on the 64th word, out_ready high.
    for (int i = 0; i < 64; i++) begin
      step("full", 1'b1, 16'(i), (i == 63), 1'b1);
      if (i == 62) chk("full.ov_before_last", 64'(out_valid), 0);
    end
    chk("full.ov_after_last", 64'(out_valid), 1);
    chk("full.err_len", 64'(err_len), 0);
    begin
      int bad = 0;
      for (int i = 0; i < 64; i++) if (x[zz[i]] !== 16'(i)) bad++;
      chk("full.x_map_errs", bad, 0);
    end
`ifndef IDCT_LOADER_ZIGZAG_EN
    chk("raster.x37", x[37], 37);
`else
    chk("zigzag.x8", x[8], 2);
`endif

    // Back-to-back blocks with out_ready low: second one is held in FULL.
    step("drain", 1'b0, 16'sd0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) begin
      blk_a[i] = 16'($urandom);
      step("blkA", 1'b1, blk_a[i], (i == 63), 1'b0);
    end
    for (int i = 0; i < 64; i++) step("blkB", 1'b1, 16'(1000 + i), (i == 63), 1'b0);
    step("full_hold", 1'b1, 16'sd99, 1'b0, 1'b0);
    chk("full_hold.in_ready", 64'(in_ready), 0);
    begin
      int bad = 0;
      for (int i = 0; i < 64; i++) if (x[zz[i]] !== blk_a[i]) bad++;
      chk("full_hold.xA_errs", bad, 0);
    end
    step("full_swap", 1'b0, 16'sd0, 1'b0, 1'b1);
    chk("full_swap.in_ready", 64'(in_ready), 1);
    chk("full_swap.x_pos5", x[zz[5]], 1005);
    step("full_swap2", 1'b0, 16'sd0, 1'b0, 1'b1);
    chk("full_swap2.out_valid", 64'(out_valid), 0);

    // 64 words without in_last, then a short block into the cleared bank.
    for (int i = 0; i < 64; i++) step("nolast", 1'b1, 16'(500 + i), 1'b0, 1'b0);
    chk("nolast.err_len", 64'(err_len), 1);
    chk("nolast.out_valid", 64'(out_valid), 1);
    step("nolast_idle", 1'b0, 16'sd0, 1'b0, 1'b0);
    chk("nolast_idle.err_len", 64'(err_len), 0);
    step("cleared", 1'b1, 16'sd7, 1'b0, 1'b1);
    step("cleared", 1'b1, 16'sd8, 1'b0, 1'b0);
    step("cleared", 1'b1, 16'sd9, 1'b1, 1'b0);
    chk("cleared.x_pos2", x[zz[2]], 9);
    chk("cleared.x_pos3", x[zz[3]], 0);
    chk("cleared.x_pos63", x[zz[63]], 0);

    // Asynchronous reset after 20 words of a block.
    for (int i = 0; i < 20; i++) step("pre_rst", 1'b1, 16'(-i - 3), 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst = 1'b0;
    step("post_rst", 1'b1, 16'sd5, 1'b1, 1'b0);
    chk("post_rst.x0", x[0], 5);
    chk("post_rst.x1", x[1], 0);

    // Randomized stream against the model.
    for (int c = 0; c < 4000; c++) begin
      rv = 16'($urandom);
      step("rand", ($urandom_range(0, 9) < 7), rv, ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 2 : 8)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
